// File: rtl/line_buffer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : line_buffer_scheduler                                         |
// | Desc     : x/y tracking and delay-line sequencing for the WIN x WIN      |
// |            window generator. Optional stats: define LBS_STATS_EN.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module line_buffer_scheduler #(
  parameter int POS_W = 11,
  parameter int WIN   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [POS_W-1:0] cfg_h_size,
  input  logic [POS_W-1:0] cfg_v_size,
  input  logic             in_vsync,
  input  logic             in_de,
  output logic             dl_ce,
  output logic             dl_rst,
  output logic [POS_W-1:0] dl_h_size,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             win_valid,
  output logic             eol,
  output logic             eof,
  output logic             busy,
  output logic             err
`ifdef LBS_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] c_ONE    = POS_W'(1);
  localparam logic [POS_W-1:0] c_WIN    = POS_W'(WIN);
  localparam logic [POS_W-1:0] c_WIN_M1 = POS_W'(WIN - 1);

  state_t           state_q, state_d;
  logic             vsync_q;
  logic [POS_W-1:0] x_cnt_q, x_cnt_d;
  logic [POS_W-1:0] y_cnt_q, y_cnt_d;
  logic [POS_W-1:0] h_q, h_d;
  logic [POS_W-1:0] v_q, v_d;
  logic             dl_ce_q, dl_ce_d;
  logic             dl_rst_q, dl_rst_d;
  logic [POS_W-1:0] x_pos_q, x_pos_d;
  logic [POS_W-1:0] y_pos_q, y_pos_d;
  logic             win_q, win_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             w_sof;
  logic             w_cfg_ok;
  logic             w_err_evt;
  logic             w_pix;
  logic [POS_W-1:0] w_h_use, w_v_use, w_xc, w_yc;

  assign w_sof    = in_vsync & ~vsync_q;
  assign w_cfg_ok = (cfg_h_size >= c_WIN) && (cfg_v_size >= c_WIN);

  always_comb begin
    state_d   = state_q;
    x_cnt_d   = x_cnt_q;
    y_cnt_d   = y_cnt_q;
    h_d       = h_q;
    v_d       = v_q;
    dl_ce_d   = 1'b0;
    dl_rst_d  = 1'b0;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    win_d     = 1'b0;
    eol_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = err_q;
    w_err_evt = 1'b0;
    w_pix     = 1'b0;
    w_h_use   = h_q;
    w_v_use   = v_q;
    w_xc      = x_cnt_q;
    w_yc      = y_cnt_q;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_SOF;
        WAIT_SOF, RUN: begin
          if (w_sof) begin
            // An SOF inside RUN aborts the frame; it then counts as a normal SOF.
            if (state_q == RUN) begin
              err_d     = 1'b1;
              w_err_evt = 1'b1;
            end
            if (w_cfg_ok) begin
              h_d      = cfg_h_size;
              v_d      = cfg_v_size;
              dl_rst_d = 1'b1;
              if (state_q == WAIT_SOF) err_d = 1'b0;
              x_cnt_d  = '0;
              y_cnt_d  = '0;
              x_pos_d  = '0;
              y_pos_d  = '0;
              state_d  = RUN;
              w_h_use  = cfg_h_size;
              w_v_use  = cfg_v_size;
              w_xc     = '0;
              w_yc     = '0;
              w_pix    = in_de;
            end else begin
              err_d     = 1'b1;
              w_err_evt = 1'b1;
              state_d   = WAIT_SOF;
            end
          end else if (state_q == RUN) begin
            if (in_de) begin
              w_pix = 1'b1;
            end else if (x_cnt_q != '0) begin
              err_d     = 1'b1;
              w_err_evt = 1'b1;
              state_d   = WAIT_SOF;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (w_pix) begin
      dl_ce_d = 1'b1;
      x_pos_d = w_xc;
      y_pos_d = w_yc;
      win_d   = (w_xc >= c_WIN_M1) && (w_yc >= c_WIN_M1);
      if (w_xc == w_h_use - c_ONE) begin
        eol_d   = 1'b1;
        x_cnt_d = '0;
        if (w_yc == w_v_use - c_ONE) begin
          eof_d   = 1'b1;
          y_cnt_d = '0;
          state_d = WAIT_SOF;
        end else begin
          y_cnt_d = w_yc + c_ONE;
        end
      end else begin
        x_cnt_d = w_xc + c_ONE;
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      h_q      <= '0;
      v_q      <= '0;
      dl_ce_q  <= 1'b0;
      dl_rst_q <= 1'b0;
      x_pos_q  <= '0;
      y_pos_q  <= '0;
      win_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= in_vsync;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      h_q      <= h_d;
      v_q      <= v_d;
      dl_ce_q  <= dl_ce_d;
      dl_rst_q <= dl_rst_d;
      x_pos_q  <= x_pos_d;
      y_pos_q  <= y_pos_d;
      win_q    <= win_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign dl_ce     = dl_ce_q;
  assign dl_rst    = dl_rst_q;
  assign dl_h_size = h_q;
  assign x_pos     = x_pos_q;
  assign y_pos     = y_pos_q;
  assign win_valid = win_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign err       = err_q;

`ifdef LBS_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (eof_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (w_err_evt && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_err_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_scheduler.sv
`default_nettype none
// Testbench for line_buffer_scheduler: scenario tasks against pixel-index arithmetic.
module tb_line_buffer_scheduler;
  localparam int POS_W = 11;
  localparam int WIN   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [POS_W-1:0] cfg_h_size = '0;
  logic [POS_W-1:0] cfg_v_size = '0;
  logic             in_vsync = 1'b0;
  logic             in_de = 1'b0;
  logic             dl_ce, dl_rst, win_valid, eol, eof, busy, err;
  logic [POS_W-1:0] dl_h_size, x_pos, y_pos;
`ifdef LBS_STATS_EN
  logic [15:0]      frame_cnt;
  logic [7:0]       err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  line_buffer_scheduler #(.POS_W(POS_W), .WIN(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_h_size(cfg_h_size), .cfg_v_size(cfg_v_size),
    .in_vsync(in_vsync), .in_de(in_de),
    .dl_ce(dl_ce), .dl_rst(dl_rst), .dl_h_size(dl_h_size),
    .x_pos(x_pos), .y_pos(y_pos), .win_valid(win_valid),
    .eol(eol), .eof(eof), .busy(busy), .err(err)
`ifdef LBS_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame (or its first npix pixels) and checks every pixel by its index.
  task automatic frame(input int h, input int v, input bit sof_pix, input int npix, input bit exp_err);
    int idx, x, y, ce_n, eol_n, eof_n, win_n;
    logic [2*POS_W+3:0] exp_v, got_v;
    ce_n = 0; eol_n = 0; eof_n = 0; win_n = 0;
    cfg_h_size = POS_W'(h);
    cfg_v_size = POS_W'(v);
    in_vsync = 1'b1;
    in_de = sof_pix;
    step();
    n_tests++;
    if ({dl_rst, busy, err, dl_h_size} !== {1'b1, 1'b1, exp_err, POS_W'(h)}) begin
      n_fail++;
      $display("FAIL sof_accept: got rst=%0b busy=%0b err=%0b hsz=%0d, want 1 1 %0b %0d",
               dl_rst, busy, err, dl_h_size, exp_err, h);
    end
    in_vsync = 1'b0;
    idx = 0;
    while (idx < npix) begin
      if (!(idx == 0 && sof_pix)) begin
        if ((idx % h == 0) && ($urandom_range(0, 2) == 0)) begin
          in_de = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            step();
            n_tests++;
            if ({dl_ce, eol, eof} !== 3'b000) begin
              n_fail++;
              $display("FAIL line_gap: got ce/eol/eof=%03b want 000", {dl_ce, eol, eof});
            end
          end
        end
        in_de = 1'b1;
        step();
      end
      x = idx % h;
      y = idx / h;
      exp_v = {1'b1, POS_W'(x), POS_W'(y), (x >= WIN-1 && y >= WIN-1), (x == h-1), (idx == h*v-1)};
      got_v = {dl_ce, x_pos, y_pos, win_valid, eol, eof};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL pixel idx=%0d: got ce=%0b x=%0d y=%0d win=%0b eol=%0b eof=%0b, want x=%0d y=%0d win=%0b eol=%0b eof=%0b",
                 idx, dl_ce, x_pos, y_pos, win_valid, eol, eof, x, y, exp_v[2], exp_v[1], exp_v[0]);
      end
      ce_n += int'(dl_ce); eol_n += int'(eol); eof_n += int'(eof); win_n += int'(win_valid);
      idx++;
    end
    if (npix == h*v) begin
      in_de = 1'b0;
      step();
      n_tests++;
      if ({dl_ce, busy, err} !== {2'b00, exp_err}) begin
        n_fail++;
        $display("FAIL frame_end: got ce=%0b busy=%0b err=%0b want 0 0 %0b", dl_ce, busy, err, exp_err);
      end
      n_tests++;
      if (ce_n != h*v || eol_n != v || eof_n != 1 || win_n != (h-WIN+1)*(v-WIN+1)) begin
        n_fail++;
        $display("FAIL frame_totals h=%0d v=%0d: got ce=%0d eol=%0d eof=%0d win=%0d want %0d %0d 1 %0d",
                 h, v, ce_n, eol_n, eof_n, win_n, h*v, v, (h-WIN+1)*(v-WIN+1));
      end
    end
  endtask

  task automatic bad_sof(input int h, input int v);
    cfg_h_size = POS_W'(h);
    cfg_v_size = POS_W'(v);
    in_vsync = 1'b1;
    in_de = 1'b0;
    step();
    in_vsync = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if ({dl_ce, dl_rst, dl_h_size, x_pos, y_pos, win_valid, eol, eof, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got ce=%0b rst=%0b hsz=%0d x=%0d y=%0d busy=%0b err=%0b want all 0",
               dl_ce, dl_rst, dl_h_size, x_pos, y_pos, busy, err);
    end
    rst_n = 1'b1;
    enable = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    frame(8, 6, 1'b0, 48, 1'b0);
    for (int i = 0; i < 3; i++) begin
      int h, v;
      h = $urandom_range(WIN, 16);
      v = $urandom_range(WIN, 9);
      frame(h, v, 1'b0, h*v, 1'b0);
    end
  endtask

  task automatic test_cfg_error();
    int bad;
    for (int i = 0; i < 4; i++) begin
      int h, v;
      h = (i == 0) ? 3 : ((i % 2 == 1) ? $urandom_range(0, WIN-1) : $urandom_range(WIN, 20));
      v = (i == 0) ? 6 : ((i % 2 == 1) ? $urandom_range(WIN, 20) : $urandom_range(0, WIN-1));
      cfg_h_size = POS_W'(h);
      cfg_v_size = POS_W'(v);
      in_vsync = 1'b1;
      in_de = 1'b0;
      step();
      n_tests++;
      if ({err, dl_rst, busy} !== 3'b100) begin
        n_fail++;
        $display("FAIL cfg_reject h=%0d v=%0d: got err=%0b rst=%0b busy=%0b want 1 0 0", h, v, err, dl_rst, busy);
      end
      in_vsync = 1'b0;
      in_de = 1'b1;
      bad = 0;
      repeat (6) begin
        step();
        bad += int'(dl_ce) + int'(dl_rst);
      end
      in_de = 1'b0;
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL cfg_no_ce: got %0d ce/rst pulses want 0", bad);
      end
    end
    frame(8, 6, 1'b0, 48, 1'b0);
  endtask

  task automatic test_short_line();
    int nshort, bad;
    nshort = $urandom_range(1, 7);
    frame(8, 6, 1'b0, 8 + nshort, 1'b0);
    in_de = 1'b0;
    step();
    n_tests++;
    if ({err, busy, dl_ce} !== 3'b100) begin
      n_fail++;
      $display("FAIL short_line n=%0d: got err=%0b busy=%0b ce=%0b want 1 0 0", nshort, err, busy, dl_ce);
    end
    in_de = 1'b1;
    bad = 0;
    repeat (12) begin
      step();
      bad += int'(dl_ce);
    end
    in_de = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL short_discard: got %0d ce pulses want 0", bad);
    end
    frame(8, 6, 1'b0, 48, 1'b0);
  endtask

  task automatic test_early_sof();
    frame(8, 6, 1'b0, 24, 1'b0);
    frame(8, 6, 1'b1, 48, 1'b1);
    frame(8, 6, 1'b0, 48, 1'b0);
  endtask

  task automatic test_enable();
    int bad;
    frame(8, 6, 1'b0, 8, 1'b0);
    enable = 1'b0;
    step();
    n_tests++;
    if ({busy, dl_ce} !== 2'b00) begin
      n_fail++;
      $display("FAIL enable_off: got busy=%0b ce=%0b want 0 0", busy, dl_ce);
    end
    in_vsync = 1'b1;
    cfg_h_size = POS_W'(8);
    cfg_v_size = POS_W'(6);
    step();
    in_vsync = 1'b0;
    bad = 0;
    repeat (6) begin
      step();
      bad += int'(dl_ce) + int'(dl_rst) + int'(busy);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL enable_ignore: got %0d ce/rst/busy cycles want 0", bad);
    end
    in_de = 1'b0;
    enable = 1'b1;
    step();
    frame(8, 6, 1'b0, 48, 1'b0);
  endtask

  task automatic test_reset_midrun();
    int bad;
    frame(8, 6, 1'b0, 10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dl_ce, dl_rst, dl_h_size, x_pos, y_pos, win_valid, eol, eof, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: got ce=%0b hsz=%0d x=%0d y=%0d busy=%0b want all 0",
               dl_ce, dl_h_size, x_pos, y_pos, busy);
    end
    step();
    rst_n = 1'b1;
    step();
    bad = 0;
    repeat (8) begin
      step();
      bad += int'(dl_ce);
    end
    in_de = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_needs_sof: got %0d ce pulses want 0", bad);
    end
    frame(8, 6, 1'b0, 48, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      int h, v;
      h = $urandom_range(WIN, 12);
      v = $urandom_range(WIN, 8);
      frame(h, v, 1'($urandom_range(0, 1)), h*v, 1'b0);
    end
  endtask

`ifdef LBS_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    frame(8, 6, 1'b0, 48, 1'b0);
    bad_sof(3, 6);
    frame(6, 5, 1'b0, 30, 1'b0);
    bad_sof(8, 2);
    frame(9, 7, 1'b0, 63, 1'b0);
    n_tests++;
    if (frame_cnt !== 16'd3 || err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL stats_count: got frames=%0d errs=%0d want 3 2", frame_cnt, err_cnt);
    end
    repeat (300) bad_sof(2, 2);
    n_tests++;
    if (frame_cnt !== 16'd3 || err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL stats_saturate: got frames=%0d errs=%0d want 3 255", frame_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_cfg_error();
    test_short_line();
    test_early_sof();
    test_enable();
    test_reset_midrun();
    test_back_to_back();
`ifdef LBS_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
